// File: rtl/apb_arb_master_pkg.sv
// Shared widths, FSM state type and command record for the two-requester APB master.
// Round-robin index helper lives here so the arbiter and any future users agree on wrap-around.
package apb_arb_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_REQ   = 2;
    localparam int unsigned REQ_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } apb_cmd_t;

    function automatic logic [REQ_IDX_W-1:0] rr_next(input logic [REQ_IDX_W-1:0] base,
                                                     input int unsigned step);
        int unsigned sum;
        sum = 32'(base) + step;
        return REQ_IDX_W'(sum % NUM_REQ);
    endfunction

endpackage

// File: rtl/apb_arb_master_if.sv
// Requester handshake plus APB completer bus for apb_arb_master.
// master = the arbitrating APB master; slave = requesters and APB completer side.
interface apb_arb_master_if;
    import apb_arb_pkg::*;

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             req_write;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [DATA_W-1:0]              rsp_rdata;
    logic                           rsp_err;

    logic                           PSELx;
    logic                           PENABLE;
    logic                           PWRITE;
    logic [ADDR_W-1:0]              PADDR;
    logic [DATA_W-1:0]              PWDATA;
    logic [DATA_W-1:0]              PRDATA;
    logic                           PREADY;
    logic                           PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_arb_master_rr_arbiter.sv
// Round-robin grant selection on a last-granted pointer (reset points at the highest index).
// Latency: combinational grant, pointer updates on the edge where gnt_take is high.
// Backpressure: none; the pointer only advances when the caller accepts the grant.
module apb_rr_arbiter
    import apb_arb_pkg::*;
(
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic [NUM_REQ-1:0]   req_vld,
    input  logic                 gnt_take,
    output logic                 gnt_vld,
    output logic [REQ_IDX_W-1:0] gnt_idx,
    output logic [NUM_REQ-1:0]   gnt_oh
);

    logic [REQ_IDX_W-1:0] last_q;
    logic [REQ_IDX_W-1:0] last_d;
    logic [REQ_IDX_W-1:0] cand;

    // Search starts one past the last winner so the last winner has lowest priority.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = last_q;
        cand    = last_q;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = rr_next(last_q, i);
            if (!gnt_vld && req_vld[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_oh = '0;
        if (gnt_vld) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
        last_d = (gnt_take && gnt_vld) ? gnt_idx : last_q;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            last_q <= REQ_IDX_W'(NUM_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// Two-requester APB master: round-robin grant in IDLE, SETUP/ACCESS phases, registered response.
// Latency: 3 cycles grant->rsp_valid with zero wait states. Backpressure: PREADY stretches ACCESS;
// APB_ARB_MASTER_TIMEOUT_EN bounds the wait at TIMEOUT_CYCLES and returns an error response.
module apb_arb_master
    import apb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_arb_master_if.master  bus
);

    apb_state_e           state_q, state_d;
    apb_cmd_t             cmd_q, cmd_d;
    logic                 psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic [REQ_IDX_W-1:0] owner_q, owner_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 run_q, run_d;

    logic                 arb_vld;
    logic [REQ_IDX_W-1:0] arb_idx;
    logic [NUM_REQ-1:0]   arb_oh;
    logic                 grant_take;
    logic                 timeout_hit;

    // run_q keeps the combinational req_ready low while reset is asserted.
    assign grant_take = run_q && (state_q == IDLE) && arb_vld;

    apb_rr_arbiter u_arb (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .req_vld  (bus.req_valid),
        .gnt_take (grant_take),
        .gnt_vld  (arb_vld),
        .gnt_idx  (arb_idx),
        .gnt_oh   (arb_oh)
    );

`ifdef APB_ARB_MASTER_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;

    always_comb begin
        timeout_hit = (state_q == ACCESS) && !bus.PREADY &&
                      (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
        wait_d      = '0;
        if ((state_q == ACCESS) && !bus.PREADY && !timeout_hit) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    logic [31:0] unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        owner_d     = owner_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        run_d       = 1'b1;
        case (state_q)
            IDLE: begin
                if (grant_take) begin
                    state_d     = SETUP;
                    owner_d     = arb_idx;
                    cmd_d.write = bus.req_write[arb_idx];
                    cmd_d.addr  = bus.req_addr[arb_idx];
                    cmd_d.wdata = bus.req_wdata[arb_idx];
                    psel_d      = 1'b1;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (bus.PREADY || timeout_hit) begin
                    state_d              = IDLE;
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d            = bus.PREADY ? bus.PSLVERR : 1'b1;
                    rsp_rdata_d          = (bus.PREADY && !cmd_q.write) ? bus.PRDATA : '0;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            owner_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            owner_q     <= owner_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            run_q       <= run_d;
        end
    end

    assign bus.req_ready = grant_take ? arb_oh : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PSELx     = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = cmd_q.write;
    assign bus.PADDR     = cmd_q.addr;
    assign bus.PWDATA    = cmd_q.wdata;

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master: per-cycle vector table plus reset-abort and wait/timeout sequences.
module tb_apb_arb_master;
    import apb_arb_pkg::*;

`ifdef APB_ARB_MASTER_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 16;
`endif

    localparam logic [31:0] A_ADDR = 32'h0000_0010;
    localparam logic [31:0] B_ADDR = 32'h0000_0020;
    localparam logic [31:0] A_WD   = 32'hA5A5_0001;
    localparam logic [31:0] B_WD   = 32'h1111_2222;
    localparam logic [31:0] P      = 32'h1234_5678;

    logic PCLK = 1'b0;
    logic PRESETn;
    int   errors = 0;
    int   checks = 0;

    always #5 PCLK = ~PCLK;

    apb_arb_master_if bus ();

    apb_arb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    typedef struct {
        logic [1:0]  rv;
        logic [1:0]  rw;
        logic        rdy_in;
        logic        err_in;
        logic [31:0] prdata;
        logic [1:0]  e_rdy;
        logic        e_psel;
        logic        e_pen;
        logic        e_pw;
        logic [31:0] e_addr;
        logic [1:0]  e_rvld;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] rv, input logic [1:0] rw, input logic rdy,
                                input logic err, input logic [31:0] prd, input logic [1:0] e_rdy,
                                input logic e_psel, input logic e_pen, input logic e_pw,
                                input logic [31:0] e_addr, input logic [1:0] e_rvld,
                                input logic [31:0] e_rdata, input logic e_err);
        vec_t v;
        v.rv = rv; v.rw = rw; v.rdy_in = rdy; v.err_in = err; v.prdata = prd;
        v.e_rdy = e_rdy; v.e_psel = e_psel; v.e_pen = e_pen; v.e_pw = e_pw; v.e_addr = e_addr;
        v.e_rvld = e_rvld; v.e_rdata = e_rdata; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at %0t, limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        bit done;
        bit seen;
        int n;

        PRESETn          = 1'b0;
        bus.req_valid    = 2'b11;
        bus.req_write    = 2'b11;
        bus.req_addr[0]  = A_ADDR;
        bus.req_addr[1]  = B_ADDR;
        bus.req_wdata[0] = A_WD;
        bus.req_wdata[1] = B_WD;
        bus.PREADY       = 1'b0;
        bus.PSLVERR      = 1'b0;
        bus.PRDATA       = 32'hFFFF_FFFF;

        // single write req0, read req1 with 2 waits, contention, slave error, cancel
        tbl.push_back(mk(2'b01, 2'b01, 1, 0, 0, 2'b01, 0, 0, 0, 0,      2'b00, 0, 0));
        tbl.push_back(mk(2'b00, 2'b01, 1, 0, 0, 2'b00, 1, 0, 1, A_ADDR, 2'b00, 0, 0));
        tbl.push_back(mk(2'b00, 2'b01, 1, 0, 0, 2'b00, 1, 1, 1, A_ADDR, 2'b00, 0, 0));
        tbl.push_back(mk(2'b00, 2'b01, 1, 0, 0, 2'b00, 0, 0, 0, 0,      2'b01, 0, 0));
        tbl.push_back(mk(2'b10, 2'b00, 1, 0, 0, 2'b10, 0, 0, 0, 0,      2'b00, 0, 0));
        tbl.push_back(mk(2'b00, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0, B_ADDR, 2'b00, 0, 0));
        tbl.push_back(mk(2'b00, 2'b00, 0, 0, 0, 2'b00, 1, 1, 0, B_ADDR, 2'b00, 0, 0));
        tbl.push_back(mk(2'b00, 2'b00, 0, 0, 0, 2'b00, 1, 1, 0, B_ADDR, 2'b00, 0, 0));
        tbl.push_back(mk(2'b00, 2'b00, 1, 0, 32'hDEAD_BEEF, 2'b00, 1, 1, 0, B_ADDR, 2'b00, 0, 0));
        tbl.push_back(mk(2'b00, 2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 0,      2'b10, 32'hDEAD_BEEF, 0));
        tbl.push_back(mk(2'b11, 2'b01, 1, 0, P, 2'b01, 0, 0, 0, 0,      2'b00, 0, 0));
        tbl.push_back(mk(2'b11, 2'b01, 1, 0, P, 2'b00, 1, 0, 1, A_ADDR, 2'b00, 0, 0));
        tbl.push_back(mk(2'b11, 2'b01, 1, 0, P, 2'b00, 1, 1, 1, A_ADDR, 2'b00, 0, 0));
        tbl.push_back(mk(2'b11, 2'b01, 1, 0, P, 2'b10, 0, 0, 0, 0,      2'b01, 0, 0));
        tbl.push_back(mk(2'b11, 2'b01, 1, 0, P, 2'b00, 1, 0, 0, B_ADDR, 2'b00, 0, 0));
        tbl.push_back(mk(2'b11, 2'b01, 1, 0, P, 2'b00, 1, 1, 0, B_ADDR, 2'b00, 0, 0));
        tbl.push_back(mk(2'b11, 2'b01, 1, 0, P, 2'b01, 0, 0, 0, 0,      2'b10, P, 0));
        tbl.push_back(mk(2'b11, 2'b01, 1, 0, P, 2'b00, 1, 0, 1, A_ADDR, 2'b00, 0, 0));
        tbl.push_back(mk(2'b11, 2'b01, 1, 0, P, 2'b00, 1, 1, 1, A_ADDR, 2'b00, 0, 0));
        tbl.push_back(mk(2'b11, 2'b01, 1, 0, P, 2'b10, 0, 0, 0, 0,      2'b01, 0, 0));
        tbl.push_back(mk(2'b00, 2'b01, 1, 0, P, 2'b00, 1, 0, 0, B_ADDR, 2'b00, 0, 0));
        tbl.push_back(mk(2'b00, 2'b01, 1, 0, P, 2'b00, 1, 1, 0, B_ADDR, 2'b00, 0, 0));
        tbl.push_back(mk(2'b00, 2'b01, 1, 0, P, 2'b00, 0, 0, 0, 0,      2'b10, P, 0));
        tbl.push_back(mk(2'b01, 2'b01, 1, 1, 32'hFFFF_FFFF, 2'b01, 0, 0, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(2'b00, 2'b01, 1, 1, 32'hFFFF_FFFF, 2'b00, 1, 0, 1, A_ADDR, 2'b00, 0, 0));
        tbl.push_back(mk(2'b00, 2'b01, 1, 1, 32'hFFFF_FFFF, 2'b00, 1, 1, 1, A_ADDR, 2'b00, 0, 0));
        tbl.push_back(mk(2'b00, 2'b01, 1, 0, 0, 2'b00, 0, 0, 0, 0,      2'b01, 0, 1));
        tbl.push_back(mk(2'b01, 2'b00, 1, 0, 0, 2'b01, 0, 0, 0, 0,      2'b00, 0, 0));
        tbl.push_back(mk(2'b10, 2'b10, 1, 0, 0, 2'b00, 1, 0, 0, A_ADDR, 2'b00, 0, 0));
        tbl.push_back(mk(2'b00, 2'b10, 0, 0, 0, 2'b00, 1, 1, 0, A_ADDR, 2'b00, 0, 0));
        tbl.push_back(mk(2'b00, 2'b00, 1, 0, 32'hCAFE_0000, 2'b00, 1, 1, 0, A_ADDR, 2'b00, 0, 0));
        tbl.push_back(mk(2'b00, 2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 0,      2'b01, 32'hCAFE_0000, 0));
        tbl.push_back(mk(2'b00, 2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 0,      2'b00, 0, 0));

        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("reset req_ready", 32'(bus.req_ready), 0);
        chk("reset PSELx",     32'(bus.PSELx),     0);
        chk("reset PENABLE",   32'(bus.PENABLE),   0);
        chk("reset PWRITE",    32'(bus.PWRITE),    0);
        chk("reset PADDR",     bus.PADDR,          0);
        chk("reset PWDATA",    bus.PWDATA,         0);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 0);
        chk("reset rsp_rdata", bus.rsp_rdata,      0);
        chk("reset rsp_err",   32'(bus.rsp_err),   0);
        bus.req_valid = 2'b00;
        PRESETn       = 1'b1;

        foreach (tbl[i]) begin
            @(posedge PCLK);
            #1;
            bus.req_valid = tbl[i].rv;
            bus.req_write = tbl[i].rw;
            bus.PREADY    = tbl[i].rdy_in;
            bus.PSLVERR   = tbl[i].err_in;
            bus.PRDATA    = tbl[i].prdata;
            @(negedge PCLK);
            chk($sformatf("v%0d req_ready", i), 32'(bus.req_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d PSELx", i),     32'(bus.PSELx),     32'(tbl[i].e_psel));
            chk($sformatf("v%0d PENABLE", i),   32'(bus.PENABLE),   32'(tbl[i].e_pen));
            chk($sformatf("v%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(tbl[i].e_rvld));
            if (tbl[i].e_psel) begin
                chk($sformatf("v%0d PWRITE", i), 32'(bus.PWRITE), 32'(tbl[i].e_pw));
                chk($sformatf("v%0d PADDR", i),  bus.PADDR,       tbl[i].e_addr);
                chk($sformatf("v%0d PWDATA", i), bus.PWDATA,
                    (tbl[i].e_addr == A_ADDR) ? A_WD : B_WD);
            end
            if (tbl[i].e_rvld != 2'b00) begin
                chk($sformatf("v%0d rsp_rdata", i), bus.rsp_rdata,      tbl[i].e_rdata);
                chk($sformatf("v%0d rsp_err", i),   32'(bus.rsp_err),   32'(tbl[i].e_err));
            end
        end

        // reset asserted in ACCESS aborts the transfer
        @(posedge PCLK); #1;
        bus.req_valid = 2'b01; bus.req_write = 2'b01; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
        @(negedge PCLK);
        chk("abort grant", 32'(bus.req_ready), 32'b01);
        @(posedge PCLK); #1;
        bus.req_valid = 2'b00;
        @(posedge PCLK); #1;
        chk("abort in ACCESS", 32'(bus.PENABLE), 1);
        #2;
        PRESETn       = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        chk("abort PSELx",   32'(bus.PSELx),   0);
        chk("abort PENABLE", 32'(bus.PENABLE), 0);
        repeat (2) begin
            @(negedge PCLK);
            chk("abort rsp_valid", 32'(bus.rsp_valid), 0);
        end
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge PCLK);
            chk("post-reset rsp_valid", 32'(bus.rsp_valid), 0);
            if (bus.req_ready != 2'b00) got = 1'b1;
        end
        if (got) begin
            chk("post-reset first grant", 32'(bus.req_ready), 32'b01);
        end else begin
            checks++; errors++;
            $display("FAIL post-reset first grant: no req_ready within 6 cycles, expected 01");
        end
        @(posedge PCLK); #1;
        bus.req_valid = 2'b00; bus.PREADY = 1'b1;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("post-reset rsp_valid", 32'(bus.rsp_valid), 32'b01);
        chk("post-reset rsp_err",   32'(bus.rsp_err),   0);

        // req1 read with PREADY held low
        @(posedge PCLK); #1;
        bus.req_valid = 2'b10; bus.req_write = 2'b00; bus.PREADY = 1'b0;
        bus.PRDATA    = 32'h5555_AAAA;
        @(negedge PCLK);
        chk("wait grant", 32'(bus.req_ready), 32'b10);
        @(posedge PCLK); #1;
        bus.req_valid = 2'b00;
`ifdef APB_ARB_MASTER_TIMEOUT_EN
        n = 0; done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge PCLK);
            if (bus.PENABLE) n++;
            if (bus.rsp_valid != 2'b00) done = 1'b1;
        end
        if (done) begin
            chk("timeout access cycles", 32'(n), 4);
            chk("timeout rsp_valid",     32'(bus.rsp_valid), 32'b10);
            chk("timeout rsp_err",       32'(bus.rsp_err),   1);
            chk("timeout rsp_rdata",     bus.rsp_rdata,      0);
            chk("timeout PSELx",         32'(bus.PSELx),     0);
        end else begin
            checks++; errors++;
            $display("FAIL timeout: no rsp_valid within 20 cycles, expected after 4 ACCESS cycles");
        end
        @(negedge PCLK);
        chk("timeout idle PSELx", 32'(bus.PSELx), 0);
`else
        seen = 1'b0;
        repeat (20) begin
            @(negedge PCLK);
            if (bus.rsp_valid != 2'b00) seen = 1'b1;
        end
        chk("long wait no rsp", 32'(seen), 0);
        chk("long wait PENABLE", 32'(bus.PENABLE), 1);
        @(posedge PCLK); #1;
        bus.PREADY = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        chk("long wait rsp_valid", 32'(bus.rsp_valid), 32'b10);
        chk("long wait rsp_rdata", bus.rsp_rdata,      32'h5555_AAAA);
        chk("long wait rsp_err",   32'(bus.rsp_err),   0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, ACCESS-phase wait limit in PCLK cycles; used only when the timeout feature is compiled in.
REQ-002 Port: PCLK  input  1  single clock; all logic on the rising edge.
REQ-003 Port: PRESETn  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: req_valid  input  2  per-requester transfer request; bit 0 is requester 0.
REQ-005 Port: req_ready  output  2  one-cycle grant/accept pulse per requester.
REQ-006 Port: req_write  input  2  per-requester direction; 1 = write.
REQ-007 Port: req_addr  input  2x32  per-requester address.
REQ-008 Port: req_wdata  input  2x32  per-requester write data.
REQ-009 Port: rsp_valid  output  2  one-cycle completion pulse to the owning requester.
REQ-010 Port: rsp_rdata  output  32  read data; 0 for writes.
REQ-011 Port: rsp_err  output  1  completion error flag.
REQ-012 Ports: PSELx, PENABLE, PWRITE  output  1 each  APB control.
REQ-013 Ports: PADDR, PWDATA  output  32 each  APB address and write data.
REQ-014 Ports: PRDATA  input  32; PREADY, PSLVERR  input  1 each  APB completer response.

Function
REQ-015 FSM states SHALL be IDLE, SETUP and ACCESS.
- IDLE -> SETUP when any req_valid=1.
- SETUP -> ACCESS unconditionally.
- ACCESS -> IDLE when PREADY=1.
REQ-016 In IDLE with a request pending, the block SHALL grant one requester, pulse its req_ready for that cycle, and latch its write/addr/wdata.
REQ-017 Arbitration SHALL be round-robin on a last-granted pointer.
- Both valid: grant the requester not granted last.
- One valid: grant it.
- After reset, requester 0 SHALL win the first contention.
REQ-018 SETUP SHALL drive PSELx=1 and PENABLE=0; ACCESS SHALL drive PSELx=1 and PENABLE=1.
- PWRITE rises in the same cycle as PSELx.
- PENABLE rises exactly one cycle later.
REQ-019 PADDR, PWRITE and PWDATA SHALL stay stable from SETUP through the last ACCESS cycle.
- In IDLE they hold their last values.
- PSELx=0 and PENABLE=0 in IDLE.
REQ-020 In the ACCESS cycle where PREADY=1, the block SHALL register the response:
- rsp_rdata = PRDATA for reads, 0 for writes.
- rsp_err = PSLVERR.
- Pulse rsp_valid[grant] in the following cycle.
REQ-021 Minimum latency SHALL be 3 cycles from grant to rsp_valid with zero wait states, giving a throughput of one transfer per 3 cycles.
REQ-022 A requester SHALL hold req_valid and its fields stable until req_ready.
- Dropping req_valid before grant is legal and SHALL cancel the request silently.
- req_valid changes during SETUP or ACCESS SHALL not affect the transfer in flight.
REQ-023 rsp_valid of a completed transfer MAY coincide with req_ready of the next grant; both SHALL be honoured.

Reset
REQ-024 While PRESETn=0:
- FSM = IDLE; pointer = requester 1 (last granted).
- All outputs = 0, including PSELx, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid, rsp_rdata and rsp_err.
REQ-025 Reset asserted mid-transfer SHALL drop PSELx and PENABLE immediately, SHALL emit no rsp_valid, and the aborted request SHALL be lost.

Configuration
REQ-026 Macro APB_ARB_MASTER_TIMEOUT_EN.
- Defined: a wait counter runs in ACCESS. After TIMEOUT_CYCLES consecutive cycles with PREADY=0, the transfer SHALL end: rsp_valid pulses with rsp_err=1 and rsp_rdata=0, and the FSM returns to IDLE.
- Undefined: no counter exists, and ACCESS waits indefinitely.

Structure
REQ-027 Package apb_arb_pkg SHALL hold ADDR_W=32, DATA_W=32, NUM_REQ=2 and the FSM state enum.
REQ-028 Round-robin grant logic SHALL be the sub-module apb_rr_arbiter; everything else is inline.

Verification
REQ-029 Single write: req0 write, addr 0x10, wdata 0xA5A5_0001, PREADY=1 -> PSELx high 2 cycles, PENABLE 1 cycle, rsp_valid[0] with rsp_err=0.
REQ-030 Read with 2 wait states: req1 read, addr 0x20, PRDATA=0xDEAD_BEEF -> ACCESS lasts 3 cycles, rsp_rdata=0xDEAD_BEEF on rsp_valid[1].
REQ-031 Contention: both valid continuously, 4 transfers -> grant order 0,1,0,1, with req_ready pulses alternating.
REQ-032 Error: PSLVERR=1 with PREADY=1 on write -> rsp_err=1, rsp_rdata=0.
REQ-033 Reset in ACCESS: PRESETn low -> PSELx/PENABLE 0 in the same cycle, no rsp_valid, next grant after release goes to requester 0.
REQ-034 Timeout build (TIMEOUT_CYCLES=4), PREADY held 0 -> rsp_valid with rsp_err=1 after 4 ACCESS cycles, then FSM in IDLE.
